// File: rtl/instruction_encoder_if.sv
// Field-bundle handshake between the program builder (master) and instruction_encoder (slave).
// Carries one RV32I instruction's worth of fields per accepted in_valid && in_ready.
interface instruction_encoder_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [2:0]      fmt;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;

  modport master (
    output in_valid, in_last, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    output in_ready
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs RV32I field bundles into instruction words and streams them to instruction RAM.
// Optional immediate range checking: define INSTR_ENCODER_RANGE_CHECK_EN.
module instruction_encoder #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  instruction_encoder_if.slave bundle,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [ILEN-1:0]     mem_wdata,
  input  logic                mem_ready,
  output logic                done,
  output logic [ADDR_W-1:0]   count,
  output logic                fmt_err,
  output logic                imm_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  state_e            state;
  state_e            state_next;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       packed_word;
  logic              fmt_bad;
  logic              accept;
  logic              wr_done;

  assign accept  = bundle.in_valid && bundle.in_ready;
  assign wr_done = mem_we && mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    bundle.in_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        // The output register frees up in the same cycle it completes, allowing one word per cycle.
        bundle.in_ready = !mem_we || mem_ready;
        if (accept && bundle.in_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    packed_word = 32'h0000_0013;
    fmt_bad     = 1'b0;
    case (bundle.fmt)
      FMT_R: packed_word = {bundle.funct7, bundle.rs2, bundle.rs1, bundle.funct3,
                            bundle.rd, bundle.opcode};
      FMT_I: packed_word = {bundle.imm[11:0], bundle.rs1, bundle.funct3,
                            bundle.rd, bundle.opcode};
      FMT_S: packed_word = {bundle.imm[11:5], bundle.rs2, bundle.rs1, bundle.funct3,
                            bundle.imm[4:0], bundle.opcode};
      FMT_B: packed_word = {bundle.imm[12], bundle.imm[10:5], bundle.rs2, bundle.rs1,
                            bundle.funct3, bundle.imm[4:1], bundle.imm[11], bundle.opcode};
      FMT_U: packed_word = {bundle.imm[31:12], bundle.rd, bundle.opcode};
      FMT_J: packed_word = {bundle.imm[20], bundle.imm[10:1], bundle.imm[11],
                            bundle.imm[19:12], bundle.rd, bundle.opcode};
      default: fmt_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_addr <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      count     <= '0;
      fmt_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        next_addr <= {base_addr[ADDR_W-1:2], 2'b00};
        count     <= '0;
        fmt_err   <= 1'b0;
      end
      if (wr_done) begin
        mem_we <= 1'b0;
        count  <= count + ADDR_W'(1);
      end
      // A new accept overrides the completion clear so back-to-back writes keep mem_we high.
      if (accept) begin
        mem_we    <= 1'b1;
        mem_addr  <= next_addr;
        mem_wdata <= ILEN'(packed_word);
        next_addr <= next_addr + ADDR_W'(4);
        if (fmt_bad) begin
          fmt_err <= 1'b1;
        end
      end
      if (state == DRAIN && wr_done) begin
        done <= 1'b1;
      end
    end
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic imm_bad;

  // Each range reduces to "all bits above the field's sign bit equal the sign bit".
  always_comb begin
    imm_bad = 1'b0;
    case (bundle.fmt)
      FMT_I, FMT_S: imm_bad = !(&bundle.imm[XLEN-1:11] || ~|bundle.imm[XLEN-1:11]);
      FMT_B:        imm_bad = bundle.imm[0] ||
                              !(&bundle.imm[XLEN-1:12] || ~|bundle.imm[XLEN-1:12]);
      FMT_J:        imm_bad = bundle.imm[0] ||
                              !(&bundle.imm[XLEN-1:20] || ~|bundle.imm[XLEN-1:20]);
      FMT_U:        imm_bad = |bundle.imm[11:0];
      default:      imm_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imm_err <= 1'b0;
    end else if (state == IDLE && start) begin
      imm_err <= 1'b0;
    end else if (accept && imm_bad) begin
      imm_err <= 1'b1;
    end
  end
`else
  assign imm_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder.
// Hand-encoded RV32I words; one task per scenario.
module tb_instruction_encoder;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        done;
  logic [15:0] count;
  logic        fmt_err;
  logic        imm_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  instruction_encoder_if #(.XLEN(32)) bus ();

  instruction_encoder #(.XLEN(32), .ILEN(32), .ADDR_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .bundle    (bus.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .done      (done),
    .count     (count),
    .fmt_err   (fmt_err),
    .imm_err   (imm_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im, input logic last);
    bus.in_valid = 1'b1;
    bus.fmt      = f;
    bus.opcode   = op;
    bus.rd       = d;
    bus.rs1      = s1;
    bus.rs2      = s2;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.imm      = im;
    bus.in_last  = last;
  endtask

  task automatic idle_bus();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] base);
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_addr got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    checks++; if ({done, fmt_err, imm_err, bus.in_ready} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags got %b want 0000", {done, fmt_err, imm_err, bus.in_ready}); end
    checks++; if (count !== 16'h0) begin errors++; $display("FAIL rst_count got %h want 0000", count); end
  endtask

  task automatic test_single_i();
    mem_ready = 1'b0;
    do_start(16'h0100);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", bus.in_ready); end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    idle_bus();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we got %b want 1", mem_we); end
    checks++; if (mem_addr !== 16'h0100) begin errors++; $display("FAIL single_addr got %h want 0100", mem_addr); end
    checks++; if (mem_wdata !== 32'h00500093) begin errors++; $display("FAIL single_wdata got %h want 00500093", mem_wdata); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL single_drain_ready got %b want 0", bus.in_ready); end
    tick();
    checks++; if ({mem_we, done} !== 2'b10) begin errors++; $display("FAIL single_hold got %b want 10", {mem_we, done}); end
    mem_ready = 1'b1;
    tick();
    checks++; if ({mem_we, done} !== 2'b01) begin errors++; $display("FAIL single_done got %b want 01", {mem_we, done}); end
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    mem_ready = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", done); end
  endtask

  task automatic test_stream();
    logic [2:0]  f   [5] = '{3'd2, 3'd4, 3'd5, 3'd3, 3'd0};
    logic [6:0]  op  [5] = '{7'h23, 7'h37, 7'h6F, 7'h63, 7'h33};
    logic [4:0]  d   [5] = '{5'd0, 5'd5, 5'd1, 5'd0, 5'd3};
    logic [4:0]  s1  [5] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd1};
    logic [4:0]  s2  [5] = '{5'd2, 5'd0, 5'd0, 5'd2, 5'd2};
    logic [2:0]  f3  [5] = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [6:0]  f7  [5] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20};
    logic [31:0] im  [5] = '{32'd8, 32'h12345000, 32'd8, 32'hFFFFFFFC, 32'd0};
    logic [31:0] exp [5] = '{32'h0020A423, 32'h123452B7, 32'h008000EF, 32'hFE208EE3, 32'h402081B3};
    mem_ready = 1'b1;
    do_start(16'h0200);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, bus.in_ready); end
      drive(f[i], op[i], d[i], s1[i], s2[i], f3[i], f7[i], im[i], i == 4);
      if (i == 2) begin
        base_addr = 16'h0900;
        start     = 1'b1;
      end
      tick();
      start = 1'b0;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL stream_we[%0d] got %b want 1", i, mem_we); end
      checks++; if (mem_addr !== 16'h0200 + 16'(4 * i)) begin
        errors++; $display("FAIL stream_addr[%0d] got %h want %h", i, mem_addr, 16'h0200 + 16'(4 * i)); end
      checks++; if (mem_wdata !== exp[i]) begin
        errors++; $display("FAIL stream_wdata[%0d] got %h want %h", i, mem_wdata, exp[i]); end
    end
    idle_bus();
    tick();
    checks++; if ({mem_we, done} !== 2'b01) begin errors++; $display("FAIL stream_done got %b want 01", {mem_we, done}); end
    checks++; if (count !== 16'd5) begin errors++; $display("FAIL stream_count got %0d want 5", count); end
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b1;
    do_start(16'h0300);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
    tick();
    mem_ready = 1'b0;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, bus.in_ready); end
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0300, 32'h00100093}) begin
        errors++; $display("FAIL bp_hold[%0d] got %b %h %h want 1 0300 00100093", i, mem_we, mem_addr, mem_wdata); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
    tick();
    checks++; if ({mem_addr, mem_wdata} !== {16'h0304, 32'h00200093}) begin
      errors++; $display("FAIL bp_w1 got %h %h want 0304 00200093", mem_addr, mem_wdata); end
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL bp_count1 got %0d want 1", count); end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0);
    tick();
    checks++; if ({mem_addr, mem_wdata} !== {16'h0308, 32'h00300093}) begin
      errors++; $display("FAIL bp_w2 got %h %h want 0308 00300093", mem_addr, mem_wdata); end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b1);
    tick();
    idle_bus();
    checks++; if ({mem_addr, mem_wdata} !== {16'h030C, 32'h00400093}) begin
      errors++; $display("FAIL bp_w3 got %h %h want 030c 00400093", mem_addr, mem_wdata); end
    tick();
    checks++; if ({done, count} !== {1'b1, 16'd4}) begin
      errors++; $display("FAIL bp_done got %b %0d want 1 4", done, count); end
  endtask

  task automatic test_wrap_fmt();
    mem_ready = 1'b1;
    do_start(16'hFFFE);
    drive(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
    tick();
    checks++; if ({mem_addr, mem_wdata} !== {16'hFFFC, 32'h00000013}) begin
      errors++; $display("FAIL wrap_w0 got %h %h want fffc 00000013", mem_addr, mem_wdata); end
    checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_err_set got %b want 1", fmt_err); end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    idle_bus();
    checks++; if ({mem_addr, mem_wdata} !== {16'h0000, 32'h00500093}) begin
      errors++; $display("FAIL wrap_w1 got %h %h want 0000 00500093", mem_addr, mem_wdata); end
    tick();
    checks++; if ({done, fmt_err} !== 2'b11) begin errors++; $display("FAIL fmt_err_sticky got %b want 11", {done, fmt_err}); end
    do_start(16'h0000);
    checks++; if (fmt_err !== 1'b0) begin errors++; $display("FAIL fmt_err_clear got %b want 0", fmt_err); end
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 1'b1);
    tick();
    idle_bus();
    checks++; if ({mem_addr, mem_wdata} !== {16'h0000, 32'h002081B3}) begin
      errors++; $display("FAIL wrap_r got %h %h want 0000 002081b3", mem_addr, mem_wdata); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_r_done got %b want 1", done); end
  endtask

  task automatic test_imm_range();
    mem_ready = 1'b1;
    do_start(16'h0400);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    tick();
    checks++; if (imm_err !== 1'b0) begin errors++; $display("FAIL imm_ok got %b want 0", imm_err); end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1);
    tick();
    idle_bus();
    checks++; if (mem_wdata !== 32'h80000093) begin errors++; $display("FAIL imm_i_wdata got %h want 80000093", mem_wdata); end
    checks++; if (imm_err !== RANGE_EN) begin errors++; $display("FAIL imm_i_err got %b want %b", imm_err, RANGE_EN); end
    tick();
    do_start(16'h0500);
    checks++; if (imm_err !== 1'b0) begin errors++; $display("FAIL imm_clear got %b want 0", imm_err); end
    drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1);
    tick();
    idle_bus();
    checks++; if (mem_wdata !== 32'h00208163) begin errors++; $display("FAIL imm_b_wdata got %h want 00208163", mem_wdata); end
    checks++; if (imm_err !== RANGE_EN) begin errors++; $display("FAIL imm_b_err got %b want %b", imm_err, RANGE_EN); end
    tick();
  endtask

  task automatic test_reset_drain();
    mem_ready = 1'b0;
    do_start(16'h0500);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    idle_bus();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rd_we_pre got %b want 1", mem_we); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({mem_we, mem_addr, mem_wdata, count} !== {1'b0, 16'h0, 32'h0, 16'h0}) begin
      errors++; $display("FAIL rd_outputs got %b %h %h %h want 0 0000 00000000 0000", mem_we, mem_addr, mem_wdata, count); end
    checks++; if ({done, bus.in_ready} !== 2'b00) begin errors++; $display("FAIL rd_flags got %b want 00", {done, bus.in_ready}); end
    mem_ready = 1'b1;
    tick();
    checks++; if ({done, mem_we} !== 2'b00) begin errors++; $display("FAIL rd_no_done got %b want 00", {done, mem_we}); end
    do_start(16'h0600);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    idle_bus();
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0600, 32'h00500093}) begin
      errors++; $display("FAIL rd_restart got %b %h %h want 1 0600 00500093", mem_we, mem_addr, mem_wdata); end
    tick();
    checks++; if ({done, count} !== {1'b1, 16'd1}) begin errors++; $display("FAIL rd_restart_done got %b %0d want 1 1", done, count); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.fmt      = '0;
    bus.opcode   = '0;
    bus.rd       = '0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.funct3   = '0;
    bus.funct7   = '0;
    bus.imm      = '0;
    test_reset();
    test_single_i();
    test_stream();
    test_backpressure();
    test_wrap_fmt();
    test_imm_range();
    test_reset_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
